uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Two-requester UART transmit scheduler for the radio link. It arbitrates round-robin between two byte sources and serialises the granted byte onto `tx` with start, data and stop bits. Bit timing comes from an internal clocks-per-bit divider. An internal data-bit counter is exposed for status and debug.

## Interface
Parameters:
- `BAUD_DIV`, default 16: clock cycles per UART bit; legal range 2..65535.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..8.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `kill_n`  in  1  asynchronous active-low reset.
- `req0_valid`  in  1  source 0 has a byte to send.
- `req0_data`  in  DATA_BITS  source 0 byte; LSB is sent first.
- `req0_ready`  out  1  source 0 transfer accepted this cycle.
- `req1_valid`  in  1  source 1 has a byte to send.
- `req1_data`  in  DATA_BITS  source 1 byte.
- `req1_ready`  out  1  source 1 transfer accepted this cycle.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress (any state other than IDLE).
- `src`  out  1  index of the most recently granted source.
- `bit_cnt`  out  4  number of data bits completed in the current frame.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **Transfer rule**: `reqN_valid && reqN_ready` in a cycle is a transfer. Ready is combinational: it is asserted only in IDLE, and only for the winning requester. At most one ready is high in any cycle.
- **Arbitration** (evaluated in IDLE only):
  - Only one source valid: that source wins.
  - Both valid: the source other than `src` wins (round-robin).
  - Neither valid: stay in IDLE.
- **On transfer**:
  - Latch the winning data into the shift register.
  - `src` <= winner.
  - Next state is START.
- **Bit timing**: a divider counts 0..BAUD_DIV-1 and is cleared on entry to every state. `bit_tick` = (divider == BAUD_DIV-1) while not in IDLE.
- **START**: `tx`=0. On `bit_tick` go to DATA.
- **DATA**:
  - `tx` = shift register LSB.
  - On `bit_tick`: shift right, `bit_cnt` += 1, clear the divider.
  - Go to STOP on the tick where `bit_cnt` reaches DATA_BITS.
- **STOP**: `tx`=1 for STOP_BITS×BAUD_DIV cycles, then go to IDLE. `bit_cnt` clears to 0 on entry to IDLE.
- **Output register**: `tx` is registered; no combinational path from inputs to `tx`.
- **Input stability**: `reqN_data` and `reqN_valid` changes outside a transfer cycle have no effect. Valid may drop without a transfer.
- **Reset values**: `tx`=1, `busy`=0, `src`=1 (so source 0 wins the first tie), `bit_cnt`=0, ready=0, state=IDLE, divider=0.
- **Reset mid-frame**:
  - Asserting `kill_n` low forces `tx` high immediately (asynchronously) and discards the frame.
  - No ready is issued while `kill_n` is low.
  - After release, the first possible transfer is the first clock edge with `kill_n` high.
- **Widths**: the divider is 16 bits. `bit_cnt` saturates by construction at DATA_BITS ≤ 8, so it never wraps.

## Timing
- Transfer at edge T:
  - `busy`=1 and `tx`=0 from T+1.
  - First data bit appears at T+1+BAUD_DIV.
  - Stop bit starts at T+1+(1+DATA_BITS)×BAUD_DIV.
- Frame occupies (1+DATA_BITS+STOP_BITS)×BAUD_DIV cycles. This is 160 cycles at the defaults.
- The FSM returns to IDLE for at least one cycle before the next transfer. With `valid` held high continuously, transfers are spaced (1+DATA_BITS+STOP_BITS)×BAUD_DIV+1 cycles apart (161 at the defaults).
- `busy` falls in the same cycle the FSM enters IDLE; ready can be high in that same cycle.
- `bit_cnt` increments one cycle after each data-bit `bit_tick` edge.

## Test plan
- **Reset**: hold `kill_n`=0, toggle all inputs -> `tx`=1, `busy`=0, both ready=0, `src`=1, `bit_cnt`=0.
- **Single byte**: `req0_valid`=1, `req0_data`=8'hA5 at the defaults -> `req0_ready` pulses 1 cycle. `tx` sequence per 16-cycle bit: 0,1,0,1,0,0,1,0,1,1. `busy` is high for 160 cycles. `bit_cnt` steps 0..8 and then clears.
- **Round-robin**: both valid continuously, data0=8'h11, data1=8'h22 -> grant order 0,1,0,1. Transfers are 161 cycles apart. `src` toggles on each transfer.
- **Single requester**: only `req1_valid` high for 3 frames -> source 1 is granted each time. `req0_ready` never asserts.
- **Reset mid-frame**: pull `kill_n` low during DATA bit 3 -> `tx`=1 within the same cycle. After release, `busy`=0 and the next valid is accepted on the first clock edge.
- **Parameter corner**: BAUD_DIV=2, DATA_BITS=5, STOP_BITS=2 -> frame length 16 cycles. `bit_cnt` ends at 5. Back-to-back spacing is 17 cycles.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Two-source round-robin UART transmitter: arbitrates in IDLE, then sends
// start, DATA_BITS data bits (LSB first) and STOP_BITS stop bits on tx.
module uart_tx_sched #(
  parameter int BAUD_DIV  = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 kill_n,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 src,
  output logic [3:0]           bit_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  BITS_LAST = 4'(DATA_BITS - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  state_t               state;
  logic [15:0]          div;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_cnt;
  logic                 bit_tick;

  assign bit_tick = (state != ST_IDLE) && (div == DIV_LAST);
  assign busy     = (state != ST_IDLE);

  // Tie goes to the source that was not granted last; kill_n gates ready so
  // nothing is accepted while the block is held in reset.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == ST_IDLE && kill_n) begin
      if (req0_valid && (!req1_valid || src)) req0_ready = 1'b1;
      else if (req1_valid)                    req1_ready = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state    <= ST_IDLE;
      div      <= 16'd0;
      shreg    <= '0;
      stop_cnt <= 1'b0;
      bit_cnt  <= 4'd0;
      src      <= 1'b1;
      tx       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          div      <= 16'd0;
          stop_cnt <= 1'b0;
          tx       <= 1'b1;
          if (req0_ready) begin
            shreg <= req0_data;
            src   <= 1'b0;
            tx    <= 1'b0;
            state <= ST_START;
          end else if (req1_ready) begin
            shreg <= req1_data;
            src   <= 1'b1;
            tx    <= 1'b0;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (bit_tick) begin
            div   <= 16'd0;
            tx    <= shreg[0];
            state <= ST_DATA;
          end else begin
            div <= div + 16'd1;
          end
        end

        ST_DATA: begin
          if (bit_tick) begin
            div     <= 16'd0;
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == BITS_LAST) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              // tx is registered, so load the bit that the shift brings to LSB
              tx <= shreg[1];
            end
          end else begin
            div <= div + 16'd1;
          end
        end

        ST_STOP: begin
          if (bit_tick) begin
            div <= 16'd0;
            if (stop_cnt == STOP_LAST) begin
              bit_cnt <= 4'd0;
              state   <= ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            div <= div + 16'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: arbitration table plus frame-level sequences
// on a default instance and a BAUD_DIV=2/DATA_BITS=5/STOP_BITS=2 instance.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       kill_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       tx, busy, src;
  logic [3:0] bit_cnt;

  logic       c_req0_valid, c_req1_valid, c_req0_ready, c_req1_ready;
  logic [4:0] c_req0_data, c_req1_data;
  logic       c_tx, c_busy, c_src;
  logic [3:0] c_bit_cnt;

  uart_tx_sched dut (
    .clk(clk), .kill_n(kill_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .src(src), .bit_cnt(bit_cnt)
  );

  uart_tx_sched #(.BAUD_DIV(2), .DATA_BITS(5), .STOP_BITS(2)) dut_c (
    .clk(clk), .kill_n(kill_n),
    .req0_valid(c_req0_valid), .req0_data(c_req0_data), .req0_ready(c_req0_ready),
    .req1_valid(c_req1_valid), .req1_data(c_req1_data), .req1_ready(c_req1_ready),
    .tx(c_tx), .busy(c_busy), .src(c_src), .bit_cnt(c_bit_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 0);
  endtask

  typedef struct {
    logic kill;
    logic v0;
    logic v1;
    logic e_r0;
    logic e_r1;
  } arb_vec_t;

  arb_vec_t arb_tab[7];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] sb_tx;
    logic [7:0] c_tx_exp;
    int busy_cnt, g_cnt, kk, g_cyc[4];
    logic g_src[4];
    logic r0_seen;

    sb_tx    = 10'b1101001010;  // A5 frame, index = bit slot
    c_tx_exp = 8'b11101010;     // 5'h15 frame at 2 cycles per bit

    // {kill_n, valid0, valid1, ready0, ready1}; src is 1 throughout
    arb_tab[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    arb_tab[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    arb_tab[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    arb_tab[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    arb_tab[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    arb_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    arb_tab[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    kill_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
    c_req0_valid = 1'b0; c_req1_valid = 1'b0; c_req0_data = 5'h00; c_req1_data = 5'h00;
    repeat (3) @(negedge clk);

    // Arbitration table: ready checked combinationally, valids dropped before the edge
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      kill_n     = arb_tab[i].kill;
      req0_valid = arb_tab[i].v0;
      req1_valid = arb_tab[i].v1;
      req0_data  = 8'(8'hF0 + i);
      req1_data  = 8'(8'h0F + i);
      #1;
      check($sformatf("arb%0d_ready0", i), 32'(req0_ready), 32'(arb_tab[i].e_r0));
      check($sformatf("arb%0d_ready1", i), 32'(req1_ready), 32'(arb_tab[i].e_r1));
      check($sformatf("arb%0d_tx", i), 32'(tx), 1);
      check($sformatf("arb%0d_busy", i), 32'(busy), 0);
      check($sformatf("arb%0d_src", i), 32'(src), 1);
      check($sformatf("arb%0d_bit_cnt", i), 32'(bit_cnt), 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end

    // Single byte A5 from source 0
    @(negedge clk);
    req0_data = 8'hA5; req0_valid = 1'b1;
    #1 check("sb_ready", 32'(req0_ready), 1);
    @(negedge clk);
    check("sb_ready_pulse", 32'(req0_ready), 0);
    req0_valid = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 180; k++) begin
      if (k > 0) @(negedge clk);
      busy_cnt += int'(busy);
      if (k % 16 == 8 && k / 16 < 10) begin
        check($sformatf("sb_tx_slot%0d", k / 16), 32'(tx), 32'(sb_tx[k / 16]));
        check($sformatf("sb_bit_cnt_slot%0d", k / 16), 32'(bit_cnt),
              (k / 16 == 0) ? 0 : (k / 16 == 9) ? 8 : k / 16 - 1);
      end
    end
    check("sb_busy_cycles", busy_cnt, 160);
    check("sb_end_bit_cnt", 32'(bit_cnt), 0);
    check("sb_end_tx", 32'(tx), 1);
    check("sb_src", 32'(src), 0);

    // Round-robin from a fresh reset (src=1 so source 0 wins first)
    @(negedge clk); kill_n = 1'b0;
    @(negedge clk); kill_n = 1'b1;
    req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    g_cnt = 0; kk = -1;
    for (int c = 0; c < 800; c++) begin
      if (g_cnt > 0) begin
        kk = c - g_cyc[g_cnt-1] - 1;
        if (kk == 0)  check($sformatf("rr_src_%0d", g_cnt - 1), 32'(src), 32'(g_src[g_cnt-1]));
        if (kk == 24) check($sformatf("rr_bit0_%0d", g_cnt - 1), 32'(tx), 32'(!g_src[g_cnt-1]));
        if (kk == 40) check($sformatf("rr_bit1_%0d", g_cnt - 1), 32'(tx), 32'(g_src[g_cnt-1]));
      end
      if (g_cnt == 4 && kk == 40) break;
      if ((req0_ready || req1_ready) && g_cnt < 4) begin
        check("rr_onehot", 32'(req0_ready && req1_ready), 0);
        g_src[g_cnt] = req1_ready;
        g_cyc[g_cnt] = c;
        g_cnt++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_grants", g_cnt, 4);
    for (int i = 0; i < 4 && i < g_cnt; i++) begin
      check($sformatf("rr_order%0d", i), 32'(g_src[i]), i % 2);
      if (i > 0) check($sformatf("rr_spacing%0d", i), g_cyc[i] - g_cyc[i-1], 161);
    end
    wait_idle("rr_idle_timeout");

    // Only source 1 requests for three frames
    @(negedge clk);
    req1_data = 8'h3C; req1_valid = 1'b1;
    #1;
    g_cnt = 0; r0_seen = 1'b0;
    for (int c = 0; c < 600 && g_cnt < 3; c++) begin
      if (req0_ready) r0_seen = 1'b1;
      if (req1_ready) g_cnt++;
      @(negedge clk);
    end
    req1_valid = 1'b0;
    check("sr_grants", g_cnt, 3);
    check("sr_no_ready0", 32'(r0_seen), 0);
    check("sr_src", 32'(src), 1);
    wait_idle("sr_idle_timeout");

    // Reset during data bit 3 of an A5 frame
    @(negedge clk);
    req0_data = 8'hA5; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (72) @(negedge clk);
    check("mr_pre_tx", 32'(tx), 0);
    check("mr_pre_bit_cnt", 32'(bit_cnt), 3);
    #2 kill_n = 1'b0;
    #1;
    check("mr_tx_async", 32'(tx), 1);
    check("mr_busy", 32'(busy), 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mr_ready0_in_reset", 32'(req0_ready), 0);
    check("mr_ready1_in_reset", 32'(req1_ready), 0);
    @(negedge clk);
    check("mr_tx_held", 32'(tx), 1);
    req0_valid = 1'b0; req1_data = 8'h5A; kill_n = 1'b1;
    #1 check("mr_ready1_release", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0;
    check("mr_accepted_busy", 32'(busy), 1);
    check("mr_accepted_tx", 32'(tx), 0);
    check("mr_accepted_src", 32'(src), 1);
    wait_idle("mr_idle_timeout");

    // Parameter corner instance, valid held high back to back
    @(negedge clk);
    c_req0_data = 5'h15; c_req0_valid = 1'b1;
    #1;
    g_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      if (g_cnt == 1) begin
        kk = c - g_cyc[0] - 1;
        if (kk < 16) busy_cnt += int'(c_busy);
        if (kk < 16 && kk % 2 == 0)
          check($sformatf("pc_tx_slot%0d", kk / 2), 32'(c_tx), 32'(c_tx_exp[kk / 2]));
        if (kk == 15) check("pc_bit_cnt_end", 32'(c_bit_cnt), 5);
        if (kk == 16) begin
          check("pc_idle_busy", 32'(c_busy), 0);
          check("pc_idle_bit_cnt", 32'(c_bit_cnt), 0);
        end
      end
      if (c_req0_ready) begin
        g_cyc[g_cnt] = c;
        g_cnt++;
      end
      if (g_cnt == 2) break;
      @(negedge clk);
    end
    c_req0_valid = 1'b0;
    check("pc_grants", g_cnt, 2);
    check("pc_busy_cycles", busy_cnt, 16);
    if (g_cnt == 2) check("pc_spacing", g_cyc[1] - g_cyc[0], 17);
    check("pc_no_ready1", 32'(c_req1_ready), 0);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
